alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 20, full-word operand width; SHALL be even and >= 4.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  rising-edge clock; one clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  unit idle and able to accept a request.
REQ-007 op  input  4  opcode, sampled on accept.
REQ-008 mode  input  1  1 = full-word (WIDTH), 0 = half-word (WIDTH/2 LSBs), sampled on accept.
REQ-009 a, b  input  WIDTH each  operands, sampled on accept.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 flags  output  3  status register {sign, carry, zero}.

Function
REQ-014 Accept occurs on a rising edge with in_valid && in_ready; in_ready SHALL equal (state == IDLE).
REQ-015 FSM states: IDLE -> EXEC on accept; EXEC -> DONE after N steps; DONE -> IDLE on out_ready; out_valid SHALL equal (state == DONE).
REQ-016 N = 1 for all non-shift ops; N = max(1, b[SHW-1:0]) for SHR/SHL/ROR/ROL; one bit position moves per EXEC cycle.
REQ-017 out_valid SHALL rise on the Nth rising edge after the accepting edge.
REQ-018 Opcodes: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 INC, 9 DEC, A ADD, B ADC, C SUB, D SBC, E CMP, F MOVB.
REQ-019 Half-word mode: operate on [WIDTH/2-1:0] only; rotates wrap within the half; result upper half SHALL be zero; flags derived from the half-word.
REQ-020 zero = (active result == 0); sign = active-result MSB; for CMP, zero = (a == b), sign = (a < b) unsigned, result = a, carry unchanged.
REQ-021 Carry: ADD/ADC/INC = carry-out; SUB/SBC/DEC = borrow; ADC/SBC use the stored carry flag as carry-in; SHR/SHL = last bit shifted out; logic, rotate and MOVB leave carry unchanged.
REQ-022 Shift/rotate amount 0: result = a, carry unchanged, N = 1.
REQ-023 flags SHALL update only on the EXEC -> DONE transition and hold otherwise.
REQ-024 result and flags SHALL remain stable while out_valid && !out_ready.
REQ-025 in_valid during EXEC or DONE SHALL be ignored; no queueing.
REQ-026 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, result 0, flags 0, step counter 0, in_ready 1, out_valid 0.
REQ-028 Reset during EXEC or DONE SHALL abort the operation with no result and no flag update.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode enum, FSM state enum and flag bit indices (SIGN=2, CARRY=1, ZERO=0).
REQ-030 Sub-module alu_step SHALL hold the combinational single-step datapath (one op or one shift bit, both modes); alu_iter holds the FSM, counter, operand and flag registers.

Verification (WIDTH=20)
REQ-031 ADD, mode=1, a=0xFFFFF, b=0x00001 -> out_valid 1 cycle after accept, result 0x00000, flags {0,1,1}.
REQ-032 ADD, mode=0, a=0xFFBFF, b=0x00001 -> result 0x00000 (upper half cleared), carry=1, zero=1.
REQ-033 SHL, mode=1, a=0x80001, b=3 -> out_valid 3 cycles after accept, result 0x00008, carry=0; in_ready low throughout.
REQ-034 CMP a=5, b=9 -> result 0x00005, sign=1, zero=0, carry unchanged from preceding op.
REQ-035 out_ready held low 5 cycles after DONE -> out_valid, result, flags stable, in_ready 0, new in_valid ignored.
REQ-036 rst_n pulsed low mid ROR with b=10 -> out_valid 0, in_ready 1, flags 0 immediately; next ADD 2+3 -> result 0x00005.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, FSM state and flag index definitions for the iterative ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOT  = 4'h0,
    OP_AND  = 4'h1,
    OP_OR   = 4'h2,
    OP_XOR  = 4'h3,
    OP_SHR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_ROR  = 4'h6,
    OP_ROL  = 4'h7,
    OP_INC  = 4'h8,
    OP_DEC  = 4'h9,
    OP_ADD  = 4'hA,
    OP_ADC  = 4'hB,
    OP_SUB  = 4'hC,
    OP_SBC  = 4'hD,
    OP_CMP  = 4'hE,
    OP_MOVB = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FLAG_SIGN  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 0;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/alu_step.sv
// rtl/alu_step.sv - combinational single-step datapath: one full op or one shift/rotate bit.
module alu_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  op_e              op_i,
  input  logic             mode_i,
  input  logic             hold_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] y_o,
  output logic [2:0]       flags_o
);

  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-H){1'b0}}, {H{1'b1}}};
  localparam logic [WIDTH:0]   ONE       = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   wide;
  logic [WIDTH:0]   cin;
  logic             carry;
  logic             cmp;
  logic             arith;

  always_comb begin
    mask    = mode_i ? {WIDTH{1'b1}} : HALF_MASK;
    cin     = {{WIDTH{1'b0}}, carry_i};
    y       = x_i;
    wide    = '0;
    carry   = carry_i;
    cmp     = 1'b0;
    arith   = 1'b0;
    flags_o = '0;

    case (op_i)
      OP_NOT:  y = ~x_i;
      OP_AND:  y = x_i & b_i;
      OP_OR:   y = x_i | b_i;
      OP_XOR:  y = x_i ^ b_i;
      OP_SHR: begin
        y     = x_i >> 1;
        carry = x_i[0];
      end
      OP_SHL: begin
        y     = x_i << 1;
        carry = mode_i ? x_i[WIDTH-1] : x_i[H-1];
      end
      OP_ROR:  y = (x_i >> 1) | ({{(WIDTH-1){1'b0}}, x_i[0]} << (mode_i ? WIDTH-1 : H-1));
      OP_ROL:  y = (x_i << 1) | {{(WIDTH-1){1'b0}}, (mode_i ? x_i[WIDTH-1] : x_i[H-1])};
      OP_INC: begin wide = {1'b0, x_i} + ONE;                 arith = 1'b1; end
      OP_DEC: begin wide = {1'b0, x_i} - ONE;                 arith = 1'b1; end
      OP_ADD: begin wide = {1'b0, x_i} + {1'b0, b_i};         arith = 1'b1; end
      OP_ADC: begin wide = {1'b0, x_i} + {1'b0, b_i} + cin;   arith = 1'b1; end
      OP_SUB: begin wide = {1'b0, x_i} - {1'b0, b_i};         arith = 1'b1; end
      OP_SBC: begin wide = {1'b0, x_i} - {1'b0, b_i} - cin;   arith = 1'b1; end
      OP_CMP:  cmp = 1'b1;
      OP_MOVB: y = b_i;
      default: y = x_i;
    endcase

    // Operands arrive pre-masked, so in half-word mode a borrow or carry lands on bit H.
    if (arith) begin
      y     = wide[WIDTH-1:0];
      carry = mode_i ? wide[WIDTH] : wide[H];
    end

    if (hold_i) begin
      y     = x_i;
      carry = carry_i;
    end

    y = y & mask;

    flags_o[FLAG_CARRY] = carry;
    flags_o[FLAG_ZERO]  = cmp ? (x_i == b_i) : (y == '0);
    flags_o[FLAG_SIGN]  = cmp ? (x_i < b_i) : (mode_i ? y[WIDTH-1] : y[H-1]);
    y_o                 = y;
  end

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - iterative ALU: handshake FSM, step counter, operand and flag registers.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-H){1'b0}}, {H{1'b1}}};
  localparam logic [SHW-1:0]   CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             mode_q, mode_d;
  logic             hold_q, hold_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       flags_q, flags_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  op_e              op_in;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] in_mask;
  logic [WIDTH-1:0] step_y;
  logic [2:0]       step_flags;

  assign op_in   = op_e'(op);
  assign amt     = b[SHW-1:0];
  assign in_mask = mode ? {WIDTH{1'b1}} : HALF_MASK;

  alu_step #(.WIDTH(WIDTH)) u_step (
    .op_i    (op_q),
    .mode_i  (mode_q),
    .hold_i  (hold_q),
    .x_i     (x_q),
    .b_i     (b_q),
    .carry_i (flags_q[FLAG_CARRY]),
    .y_o     (step_y),
    .flags_o (step_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOT;
      mode_q   <= 1'b0;
      hold_q   <= 1'b0;
      x_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      hold_q   <= hold_d;
      x_q      <= x_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mode_d   = mode_q;
    hold_d   = hold_q;
    x_d      = x_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_EXEC;
          op_d    = op_in;
          mode_d  = mode;
          x_d     = a & in_mask;
          b_d     = b & in_mask;
          // A zero shift amount still takes one pass-through EXEC cycle.
          hold_d  = is_shift(op_in) && (amt == '0);
          cnt_d   = (is_shift(op_in) && (amt != '0)) ? amt : CNT_ONE;
        end
      end
      S_EXEC: begin
        if (cnt_q == CNT_ONE) begin
          state_d  = S_DONE;
          result_d = step_y;
          flags_d  = step_flags;
          cnt_d    = '0;
        end else begin
          x_d   = step_y;
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - scoreboard bench for alu_iter with directed and random requests.
module tb_alu_iter;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   t_op = 4'h0;
  logic         t_mode = 1'b1;
  logic [W-1:0] t_a = '0;
  logic [W-1:0] t_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [2:0]   flags;

  alu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (t_op),
    .mode      (t_mode),
    .a         (t_a),
    .b         (t_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   fl;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic m_carry = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   mon_pv = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference behaviour from plain arithmetic on the active word width.
  function automatic void model(input logic [3:0] o, input logic md, input logic [W-1:0] aa,
                                input logic [W-1:0] bb, input logic cf,
                                output logic [W-1:0] r, output logic [2:0] fl, output int lat);
    int     w   = md ? W : W / 2;
    longint m   = (longint'(1) << w) - 1;
    longint A   = longint'(aa) & m;
    longint B   = longint'(bb) & m;
    longint C   = longint'(cf);
    int     amt = int'(bb[4:0]);
    int     k   = amt % w;
    longint R   = A;
    logic   c   = cf;
    logic   s, z;
    lat = 1;
    case (o)
      4'h0: R = ~A & m;
      4'h1: R = A & B;
      4'h2: R = A | B;
      4'h3: R = A ^ B;
      4'h4: if (amt != 0) begin R = A >> amt; c = ((A >> (amt - 1)) & 1) != 0; lat = amt; end
      4'h5: if (amt != 0) begin
              R = (A << amt) & m;
              c = (amt <= w) ? (((A >> (w - amt)) & 1) != 0) : 1'b0;
              lat = amt;
            end
      4'h6: begin R = ((A >> k) | (A << (w - k))) & m; if (amt != 0) lat = amt; end
      4'h7: begin R = ((A << k) | (A >> (w - k))) & m; if (amt != 0) lat = amt; end
      4'h8: begin R = A + 1; c = R > m; R = R & m; end
      4'h9: begin c = (A == 0); R = (A - 1) & m; end
      4'hA: begin R = A + B; c = R > m; R = R & m; end
      4'hB: begin R = A + B + C; c = R > m; R = R & m; end
      4'hC: begin c = A < B; R = (A - B) & m; end
      4'hD: begin c = A < (B + C); R = (A - B - C) & m; end
      4'hE: R = A;
      default: R = B;
    endcase
    z = (R == 0);
    s = ((R >> (w - 1)) & 1) != 0;
    if (o == 4'hE) begin
      z = (A == B);
      s = (A < B);
    end
    r  = R[W-1:0];
    fl = {s, c, z};
  endfunction

  task automatic issue(input logic [3:0] o, input logic md, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL issue_timeout: in_ready %0b expected 1 within 200 cycles", in_ready);
      return;
    end
    t_op = o; t_mode = md; t_a = aa; t_b = bb; in_valid = 1'b1;
    model(o, md, aa, bb, m_carry, e.res, e.fl, e.lat);
    m_carry = e.fl[1];
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || !in_ready) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0 || !in_ready) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) mon_pv = 1'b0;
      else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_output: result %0h with no request pending, expected none", result);
          end else if (!mon_pv) begin
            chk("latency", cyc - sb[0].acc, sb[0].lat);
            chk("result", result, sb[0].res);
            chk("flags", flags, sb[0].fl);
          end else begin
            chk("hold_result", result, sb[0].res);
            chk("hold_flags", flags, sb[0].fl);
          end
          if (out_ready && sb.size() != 0) void'(sb.pop_front());
        end
        mon_pv = out_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r0;
    logic [2:0]   f0;
    int           guard;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    issue(4'hA, 1'b1, 20'hFFFFF, 20'h00001);
    issue(4'hA, 1'b0, 20'hFFBFF, 20'h00001);
    issue(4'h5, 1'b1, 20'h80001, 20'd3);
    repeat (3) begin
      chk("shl_in_ready", in_ready, 0);
      @(negedge clk);
    end
    issue(4'hA, 1'b1, 20'hFFFFF, 20'h00001);
    issue(4'hE, 1'b1, 20'd5, 20'd9);
    issue(4'h4, 1'b0, 20'h003FF, 20'd0);
    issue(4'h7, 1'b0, 20'h00201, 20'd1);

    drain();
    @(posedge clk); #2 out_ready = 1'b0;
    issue(4'h3, 1'b1, W'($urandom), W'($urandom));
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("stall_out_valid", out_valid, 1);
    r0 = result;
    f0 = flags;
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1; t_op = 4'hA; t_a = W'($urandom); t_b = W'($urandom);
      chk("stall_valid", out_valid, 1);
      chk("stall_result", result, r0);
      chk("stall_flags", flags, f0);
      chk("stall_in_ready", in_ready, 0);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;

    drain();
    issue(4'h6, 1'b1, W'($urandom), 20'd10);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_flags", flags, 0);
    sb.delete();
    m_carry = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    issue(4'hA, 1'b1, 20'd2, 20'd3);

    drain();
    @(posedge clk); #2 rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), 1'($urandom), W'($urandom), W'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
